// File: rtl/ext_pipe_pkg.sv
// rtl/ext_pipe_pkg.sv - shared op codes, widths and constants for the extender pipe
package ext_pipe_pkg;

    localparam int EXT_OP_W = 3;

    typedef enum logic [EXT_OP_W-1:0] {
        OP_ZERO  = 3'd0,
        OP_SIGN  = 3'd1,
        OP_UPPER = 3'd2,
        OP_LB    = 3'd3,
        OP_LBU   = 3'd4,
        OP_LH    = 3'd5,
        OP_LHU   = 3'd6,
        OP_LW    = 3'd7
    } ext_op_e;

    // Returned on misaligned loads and undefined op codes; sliced to DATA_W by users.
    localparam logic [63:0] ERR_VALUE = '1;

    function automatic int off_width(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/ext_core.sv
// rtl/ext_core.sv - combinational immediate/load-data extend, lane select and alignment fault
module ext_core
    import ext_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int OP_W   = EXT_OP_W
) (
    input  logic [OP_W-1:0]              op,
    input  logic [IMM_W-1:0]             imm,
    input  logic [DATA_W-1:0]            mem_word,
    input  logic [off_width(DATA_W)-1:0] offset,
    output logic [DATA_W-1:0]            result,
    output logic                         fault
);

    logic [DATA_W-1:0] shifted;

    // Little-endian lane k lands in the low bits after shifting right by 8*k.
    assign shifted = mem_word >> {offset, 3'b000};

    always_comb begin
        result = ERR_VALUE[DATA_W-1:0];
        fault  = 1'b0;
        case (op)
            OP_ZERO: begin
                result             = '0;
                result[IMM_W-1:0]  = imm;
            end
            OP_SIGN: begin
                result             = {DATA_W{imm[IMM_W-1]}};
                result[IMM_W-1:0]  = imm;
            end
            OP_UPPER: begin
                result                   = '0;
                result[DATA_W-1 -: IMM_W] = imm;
            end
            OP_LB, OP_LBU: begin
                result       = {DATA_W{(op == OP_LB) && shifted[7]}};
                result[7:0]  = shifted[7:0];
            end
            OP_LH, OP_LHU: begin
                if (offset[0]) begin
                    fault = 1'b1;
                end else begin
                    result        = {DATA_W{(op == OP_LH) && shifted[15]}};
                    result[15:0]  = shifted[15:0];
                end
            end
            OP_LW: begin
                if (offset[1:0] != 2'b00) begin
                    fault = 1'b1;
                end else begin
                    result        = {DATA_W{shifted[31]}};
                    result[31:0]  = shifted[31:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - valid/ready pipelined extender with flush and misalignment fault
module ext_pipe
    import ext_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int STAGES = 1,
    parameter int OP_W   = EXT_OP_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OP_W-1:0]              op,
    input  logic [IMM_W-1:0]             imm,
    input  logic [DATA_W-1:0]            mem_word,
    input  logic [off_width(DATA_W)-1:0] offset,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            result,
    output logic                         fault
);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] rdy;
    logic [DATA_W-1:0] data_q [STAGES];
    logic              flt_q  [STAGES];
    logic [DATA_W-1:0] core_result;
    logic              core_fault;

    ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .OP_W   (OP_W)
    ) u_core (
        .op       (op),
        .imm      (imm),
        .mem_word (mem_word),
        .offset   (offset),
        .result   (core_result),
        .fault    (core_fault)
    );

    // Ready ripples back from the consumer: a stage can load if it is empty or drains this cycle.
    always_comb begin : ready_chain
        logic r;
        r   = out_ready;
        rdy = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            r      = !v[i] || r;
            rdy[i] = r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
                flt_q[i]  <= 1'b0;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            if (rdy[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= core_result;
                    flt_q[0]  <= core_fault;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (rdy[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        data_q[i] <= data_q[i-1];
                        flt_q[i]  <= flt_q[i-1];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[STAGES-1];
    assign result    = data_q[STAGES-1];
    assign fault     = flt_q[STAGES-1];

endmodule

// File: tb/tb_ext_pipe.sv
// tb/tb_ext_pipe.sv - scoreboard bench for ext_pipe with a reference extension model
module tb_ext_pipe;

    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;
    localparam int STAGES = 3;
    localparam int OP_W   = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [OP_W-1:0]   op = '0;
    logic [IMM_W-1:0]  imm = '0;
    logic [DATA_W-1:0] mem_word = '0;
    logic [1:0]        offset = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] result;
    logic              fault;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [32:0] exp_q [$];
    logic        stall = 1'b0;
    logic [31:0] held_res;
    logic        held_flt;

    ext_pipe #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .STAGES (STAGES),
        .OP_W   (OP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .imm       (imm),
        .mem_word  (mem_word),
        .offset    (offset),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .fault     (fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [32:0] model(input int o, input logic [15:0] i,
                                          input logic [31:0] m, input int f);
        logic [31:0] r;
        logic        flt;
        r   = 32'hFFFF_FFFF;
        flt = 1'b0;
        case (o)
            0: r = 32'(i);
            1: r = (i >= 16'h8000) ? 32'(i) + 32'hFFFF_0000 : 32'(i);
            2: r = 32'(i) * 32'd65536;
            3, 4: begin
                r = (m >> (8 * f)) % 32'd256;
                if (o == 3 && r >= 32'd128) r = r + 32'hFFFF_FF00;
            end
            5, 6: begin
                if (f % 2 != 0) flt = 1'b1;
                else begin
                    r = (m >> (8 * f)) % 32'd65536;
                    if (o == 5 && r >= 32'd32768) r = r + 32'hFFFF_0000;
                end
            end
            7: begin
                if (f != 0) flt = 1'b1;
                else r = m;
            end
            default: ;
        endcase
        return {flt, r};
    endfunction

    // Scoreboard monitor: outputs popped first, then flush discards or acceptance pushes.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall = 1'b0;
        end else begin
            if (out_valid) begin
                if (stall) begin
                    total++;
                    if (result !== held_res || fault !== held_flt) begin
                        bad++;
                        $display("FAIL stall_hold: got %h/%b want %h/%b", result, fault, held_res, held_flt);
                    end
                end
                if (out_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_output: got %h/%b want none", result, fault);
                    end else begin
                        logic [32:0] e;
                        e = exp_q.pop_front();
                        if ({fault, result} !== e) begin
                            bad++;
                            $display("FAIL result: got %h/%b want %h/%b", result, fault, e[31:0], e[32]);
                        end
                    end
                    stall = 1'b0;
                end else begin
                    stall    = 1'b1;
                    held_res = result;
                    held_flt = fault;
                end
            end else begin
                stall = 1'b0;
            end
            if (flush) begin
                exp_q.delete();
                stall = 1'b0;
            end else if (in_valid && in_ready) begin
                exp_q.push_back(model(int'(op), imm, mem_word, int'(offset)));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the acceptance edge.
    task automatic send(input logic [2:0] o, input logic [15:0] i, input logic [31:0] m, input logic [1:0] f);
        op = o; imm = i; mem_word = m; offset = f; in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc = cyc;
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        total++; bad++;
        $display("FAIL send_timeout: got no in_ready want in_ready");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic latency_check(input string name);
        logic seen;
        seen = 1'b0;
        out_ready = 1'b1;
        send(3'd1, 16'h1234, 32'h0, 2'd0);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check(name, 32'(cyc - acc_cyc), 32'(STAGES));
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        latency_check("latency");

        out_ready = 1'b1;
        send(3'd1, 16'h8001, 32'h0, 2'd0);
        send(3'd0, 16'h8001, 32'h0, 2'd0);
        send(3'd2, 16'h8001, 32'h0, 2'd0);
        send(3'd3, 16'h0, 32'h80FF7F01, 2'd1);
        send(3'd3, 16'h0, 32'h80FF7F01, 2'd2);
        send(3'd4, 16'h0, 32'h80FF7F01, 2'd2);
        send(3'd5, 16'h0, 32'h80FF7F01, 2'd2);
        send(3'd6, 16'h0, 32'h80FF7F01, 2'd0);
        send(3'd7, 16'h0, 32'h80FF7F01, 2'd0);
        send(3'd5, 16'h0, 32'h80FF7F01, 2'd1);
        send(3'd7, 16'h0, 32'h80FF7F01, 2'd2);
        send(3'd6, 16'h0, 32'h80FF7F01, 2'd2);
        send(3'd7, 16'h0, 32'h80FF7F01, 2'd3);
        send(3'd5, 16'h0, 32'h80FF7F01, 2'd0);
        drain();

        out_ready = 1'b0;
        send(3'd3, 16'h0, 32'h11223344, 2'd0);
        send(3'd4, 16'h0, 32'h11223344, 2'd3);
        send(3'd6, 16'h0, 32'hA5A5C3C3, 2'd2);
        op = 3'd2; imm = 16'hBEEF; in_valid = 1'b1;
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'd2, 16'hBEEF, 32'h0, 2'd0);
        send(3'd5, 16'h0, 32'h8001FFFF, 2'd2);
        send(3'd1, 16'h7FFF, 32'h0, 2'd0);
        drain();

        out_ready = 1'b0;
        send(3'd0, 16'h0001, 32'h0, 2'd0);
        send(3'd0, 16'h0002, 32'h0, 2'd0);
        op = 3'd0; imm = 16'h0003; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        send(3'd3, 16'h0, 32'hDEADBEEF, 2'd0);
        send(3'd3, 16'h0, 32'hDEADBEEF, 2'd1);
        send(3'd3, 16'h0, 32'hDEADBEEF, 2'd2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("areset_out_valid", 32'(out_valid), 32'd0);
        check("areset_result", result, 32'd0);
        check("areset_fault", 32'(fault), 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        latency_check("latency_after_reset");
        drain();

        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom % 4) != 0;
            op        = 3'($urandom);
            imm       = 16'($urandom);
            mem_word  = $urandom;
            offset    = 2'($urandom);
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 40) == 0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        flush = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
